// File: rtl/param_loader_pkg.sv
// Shared types and constants for the UART-driven pulse-sequencer parameter loader.
package param_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
`ifdef PARAM_LOADER_CHECKSUM_EN
    CSUM  = 3'd4,
`endif
    WRITE = 3'd3
  } state_t;

  localparam logic [7:0] HEADER            = 8'hA5;
  localparam logic [7:0] ADDR_PERIOD       = 8'h00;
  localparam logic [7:0] ADDR_P1WIDTH      = 8'h01;
  localparam logic [7:0] ADDR_DELAY        = 8'h02;
  localparam logic [7:0] ADDR_P2WIDTH      = 8'h03;
  localparam logic [7:0] ADDR_PRE_ATT      = 8'h04;
  localparam logic [7:0] ADDR_POST_ATT     = 8'h05;
  localparam logic [7:0] ADDR_PULSE_BLOCK  = 8'h06;
  localparam logic [7:0] ADDR_PULSE_BLKOFF = 8'h07;
  localparam logic [7:0] ADDR_BLOCK        = 8'h08;
  localparam logic [7:0] ADDR_PUMP         = 8'h09;
  localparam logic [7:0] ADDR_CPMG         = 8'h0A;
  localparam logic [7:0] ADDR_COMMIT       = 8'h0F;

  localparam logic [6:0] PRE_ATT_DEF  = 7'd127;
  localparam logic [6:0] POST_ATT_DEF = 7'd127;
  localparam logic [7:0] CPMG_DEF     = 8'd1;
  localparam logic       PUMP_DEF     = 1'b1;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] p1width;
    logic [31:0] delay;
    logic [31:0] p2width;
    logic [6:0]  pre_att;
    logic [6:0]  post_att;
    logic [7:0]  pulse_block;
    logic [15:0] pulse_block_off;
    logic [7:0]  cpmg;
    logic        block;
    logic        pump;
  } param_set_t;

endpackage

// File: rtl/param_frame_rx.sv
// Frame receiver: A5, address, 4 data bytes LSB first, optional checksum when
// PARAM_LOADER_CHECKSUM_EN is defined; emits a one-cycle write strobe.
module param_frame_rx
  import param_loader_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_stb,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        frame_err
);

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] gap_q, gap_d;
  logic        rdy_q;
  logic        accept_s;
`ifdef PARAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign accept_s = rx_valid & rdy_q;
  assign rx_ready = rdy_q;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    idx_d     = idx_q;
    wr_stb    = 1'b0;
    frame_err = 1'b0;
    gap_d     = (accept_s || state_q == IDLE) ? 32'd0 : gap_q + 32'd1;
`ifdef PARAM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s && rx_data == HEADER) state_d = ADDR;
      end
      ADDR: begin
        if (accept_s) begin
          addr_d  = rx_data;
          idx_d   = 2'd0;
          state_d = DATA;
`ifdef PARAM_LOADER_CHECKSUM_EN
          csum_d  = rx_data;
`endif
        end
      end
      DATA: begin
        if (accept_s) begin
          data_d = {rx_data, data_q[31:8]};
          idx_d  = idx_q + 2'd1;
`ifdef PARAM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
          if (idx_q == 2'd3) state_d = CSUM;
`else
          if (idx_q == 2'd3) state_d = WRITE;
`endif
        end
      end
`ifdef PARAM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept_s) begin
          if (rx_data == csum_q) begin
            state_d = WRITE;
          end else begin
            frame_err = 1'b1;
            state_d   = IDLE;
          end
        end
      end
`endif
      WRITE: begin
        // A header arriving during the strobe cycle must not be lost.
        wr_stb  = 1'b1;
        state_d = (accept_s && rx_data == HEADER) ? ADDR : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_q != WRITE && !accept_s && gap_q >= TIMEOUT) begin
      frame_err = 1'b1;
      state_d   = IDLE;
      gap_d     = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 8'd0;
      data_q  <= 32'd0;
      idx_q   <= 2'd0;
      gap_q   <= 32'd0;
      rdy_q   <= 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      rdy_q   <= 1'b1;
`ifdef PARAM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: rtl/param_loader.sv
// Shadow/live parameter registers loaded over UART frames; live set updates only
// at cycle_start after a commit. Checksum byte enabled by PARAM_LOADER_CHECKSUM_EN.
module param_loader
  import param_loader_pkg::*;
#(
  parameter logic [31:0] DEF_PERIOD  = 32'd20000,
  parameter logic [31:0] DEF_P1WIDTH = 32'd40,
  parameter logic [31:0] DEF_DELAY   = 32'd2000,
  parameter logic [31:0] DEF_P2WIDTH = 32'd80,
  parameter logic [31:0] TIMEOUT     = 32'd200000
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        cycle_start,
  output logic [31:0] period,
  output logic [31:0] p1width,
  output logic [31:0] delay,
  output logic [31:0] p2width,
  output logic [6:0]  pre_att,
  output logic [6:0]  post_att,
  output logic [7:0]  pulse_block,
  output logic [15:0] pulse_block_off,
  output logic [7:0]  cpmg,
  output logic        block,
  output logic        pump,
  output logic        pending,
  output logic        frame_err
);

  localparam param_set_t DEFAULTS = '{
    period: DEF_PERIOD, p1width: DEF_P1WIDTH, delay: DEF_DELAY, p2width: DEF_P2WIDTH,
    pre_att: PRE_ATT_DEF, post_att: POST_ATT_DEF, pulse_block: 8'd0,
    pulse_block_off: 16'd0, cpmg: CPMG_DEF, block: 1'b0, pump: PUMP_DEF};

  param_set_t  shadow_q, shadow_d, live_q, live_d;
  logic        pending_q, pending_d;
  logic        frame_err_q, frame_err_d;
  logic        wr_stb_s, rx_err_s, map_err_s, commit_s;
  logic [7:0]  wr_addr_s;
  logic [31:0] wr_data_s;

  param_frame_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk       (clk_pll),
    .rst       (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .wr_stb    (wr_stb_s),
    .wr_addr   (wr_addr_s),
    .wr_data   (wr_data_s),
    .frame_err (rx_err_s)
  );

  always_comb begin
    shadow_d  = shadow_q;
    map_err_s = 1'b0;
    commit_s  = 1'b0;
    if (wr_stb_s) begin
      case (wr_addr_s)
        ADDR_PERIOD:       shadow_d.period          = wr_data_s;
        ADDR_P1WIDTH:      shadow_d.p1width         = wr_data_s;
        ADDR_DELAY:        shadow_d.delay           = wr_data_s;
        ADDR_P2WIDTH:      shadow_d.p2width         = wr_data_s;
        ADDR_PRE_ATT:      shadow_d.pre_att         = wr_data_s[6:0];
        ADDR_POST_ATT:     shadow_d.post_att        = wr_data_s[6:0];
        ADDR_PULSE_BLOCK:  shadow_d.pulse_block     = wr_data_s[7:0];
        ADDR_PULSE_BLKOFF: shadow_d.pulse_block_off = wr_data_s[15:0];
        ADDR_BLOCK:        shadow_d.block           = wr_data_s[0];
        ADDR_PUMP:         shadow_d.pump            = wr_data_s[0];
        ADDR_CPMG:         shadow_d.cpmg            = wr_data_s[7:0];
        ADDR_COMMIT:       commit_s                 = 1'b1;
        default:           map_err_s                = 1'b1;
      endcase
    end
    // Copy uses the pre-write shadow; a coincident commit re-arms pending.
    live_d    = live_q;
    pending_d = pending_q;
    if (pending_q && cycle_start) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (commit_s) pending_d = 1'b1;
    frame_err_d = rx_err_s | map_err_s;
  end

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      shadow_q    <= DEFAULTS;
      live_q      <= DEFAULTS;
      pending_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      live_q      <= live_d;
      pending_q   <= pending_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign period          = live_q.period;
  assign p1width         = live_q.p1width;
  assign delay           = live_q.delay;
  assign p2width         = live_q.p2width;
  assign pre_att         = live_q.pre_att;
  assign post_att        = live_q.post_att;
  assign pulse_block     = live_q.pulse_block;
  assign pulse_block_off = live_q.pulse_block_off;
  assign cpmg            = live_q.cpmg;
  assign block           = live_q.block;
  assign pump            = live_q.pump;
  assign pending         = pending_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader; checksum cases run only with PARAM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_param_loader;

  localparam logic [31:0] TMO = 32'd40;

  logic        clk_pll = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        cycle_start;
  logic [31:0] period, p1width, delay, p2width;
  logic [6:0]  pre_att, post_att;
  logic [7:0]  pulse_block, cpmg;
  logic [15:0] pulse_block_off;
  logic        block, pump, pending, frame_err;

  int n_vec = 0;
  int n_err = 0;
  int err_pulses = 0;
  int err_base;

  always #2.5 clk_pll = ~clk_pll;

  always @(negedge clk_pll) if (frame_err === 1'b1) err_pulses++;

  param_loader #(.TIMEOUT(TMO)) dut (
    .clk_pll(clk_pll), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .cycle_start(cycle_start), .period(period), .p1width(p1width),
    .delay(delay), .p2width(p2width), .pre_att(pre_att), .post_att(post_att),
    .pulse_block(pulse_block), .pulse_block_off(pulse_block_off), .cpmg(cpmg),
    .block(block), .pump(pump), .pending(pending), .frame_err(frame_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] csum(input logic [7:0] a, input logic [31:0] d);
    return a ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_pll);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_pll);
    rx_valid = 1'b0;
  endtask

  // cs_on_write raises cycle_start exactly in the WRITE strobe cycle.
  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic cs_on_write);
    logic [7:0] last;
    send_byte(8'hA5);
    send_byte(a);
    for (int i = 0; i < 3; i++) send_byte(d[8*i +: 8]);
`ifdef PARAM_LOADER_CHECKSUM_EN
    send_byte(d[31:24]);
    last = csum(a, d);
`else
    last = d[31:24];
`endif
    @(negedge clk_pll);
    rx_data  = last;
    rx_valid = 1'b1;
    @(negedge clk_pll);
    rx_valid    = 1'b0;
    cycle_start = cs_on_write;
    @(negedge clk_pll);
    cycle_start = 1'b0;
    repeat (2) @(negedge clk_pll);
  endtask

  task automatic pulse_cs();
    @(negedge clk_pll);
    cycle_start = 1'b1;
    @(negedge clk_pll);
    cycle_start = 1'b0;
  endtask

  task automatic check_defaults(input string tag);
    check_val({tag, "_period"},  period,         32'd20000);
    check_val({tag, "_p1width"}, p1width,        32'd40);
    check_val({tag, "_delay"},   delay,          32'd2000);
    check_val({tag, "_p2width"}, p2width,        32'd80);
    check_val({tag, "_pre"},     {25'd0, pre_att},  32'd127);
    check_val({tag, "_post"},    {25'd0, post_att}, 32'd127);
    check_val({tag, "_pblk"},    {24'd0, pulse_block}, 32'd0);
    check_val({tag, "_pboff"},   {16'd0, pulse_block_off}, 32'd0);
    check_val({tag, "_cpmg"},    {24'd0, cpmg},  32'd1);
    check_val({tag, "_block"},   {31'd0, block}, 32'd0);
    check_val({tag, "_pump"},    {31'd0, pump},  32'd1);
    check_val({tag, "_pending"}, {31'd0, pending},   32'd0);
    check_val({tag, "_ferr"},    {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; cycle_start = 1'b0;
    repeat (3) @(negedge clk_pll);
    check_val("rst_ready", {31'd0, rx_ready}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_pll);
    check_defaults("rst");
    check_val("ready_after_rst", {31'd0, rx_ready}, 32'd1);

    // Period 10000 then commit; live changes only at cycle_start.
    send_frame(8'h00, 32'd10000, 1'b0);
    send_frame(8'h0F, 32'd0, 1'b0);
    check_val("commit_pending", {31'd0, pending}, 32'd1);
    check_val("period_before_cs", period, 32'd20000);
    pulse_cs();
    check_val("period_after_cs", period, 32'd10000);
    check_val("pending_cleared", {31'd0, pending}, 32'd0);

    // Field widths truncate upper data bits.
    send_frame(8'h01, 32'h0000_0055, 1'b0);
    send_frame(8'h02, 32'h0000_0BB8, 1'b0);
    send_frame(8'h03, 32'h0000_0064, 1'b0);
    send_frame(8'h04, 32'hFFFF_FFC8, 1'b0);
    send_frame(8'h05, 32'h0000_0015, 1'b0);
    send_frame(8'h06, 32'h1234_567E, 1'b0);
    send_frame(8'h07, 32'hABCD_BEEF, 1'b0);
    send_frame(8'h08, 32'hFFFF_FFFF, 1'b0);
    send_frame(8'h09, 32'h0000_0002, 1'b0);
    send_frame(8'h0A, 32'h1234_5603, 1'b0);
    check_val("cpmg_not_live_yet", {24'd0, cpmg}, 32'd1);
    send_frame(8'h0F, 32'h0000_0000, 1'b0);
    pulse_cs();
    check_val("p1width", p1width, 32'h55);
    check_val("delay",   delay,   32'd3000);
    check_val("p2width", p2width, 32'd100);
    check_val("pre_att_trunc", {25'd0, pre_att}, 32'h48);
    check_val("post_att", {25'd0, post_att}, 32'h15);
    check_val("pulse_block", {24'd0, pulse_block}, 32'h7E);
    check_val("pulse_block_off", {16'd0, pulse_block_off}, 32'hBEEF);
    check_val("block", {31'd0, block}, 32'd1);
    check_val("pump",  {31'd0, pump},  32'd0);
    check_val("cpmg",  {24'd0, cpmg},  32'h03);
    check_val("period_kept", period, 32'd10000);

    // Unmapped address: one error pulse, no pending.
    err_base = err_pulses;
    send_frame(8'h0B, 32'h0000_0001, 1'b0);
    check_val("unmapped_err", err_pulses - err_base, 32'd1);
    check_val("unmapped_no_pending", {31'd0, pending}, 32'd0);

`ifdef PARAM_LOADER_CHECKSUM_EN
    err_base = err_pulses;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h34);
    send_byte(8'h12); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (3) @(negedge clk_pll);
    check_val("bad_csum_err", err_pulses - err_base, 32'd1);
    check_val("bad_csum_no_pending", {31'd0, pending}, 32'd0);
    send_frame(8'h0F, 32'd0, 1'b0);
    pulse_cs();
    check_val("bad_csum_shadow_kept", period, 32'd10000);
`endif

    // Partial frame then silence longer than the timeout.
    err_base = err_pulses;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
    repeat (TMO + 4) @(negedge clk_pll);
    check_val("timeout_err", err_pulses - err_base, 32'd1);
    send_frame(8'h00, 32'h0000_3000, 1'b0);
    send_frame(8'h0F, 32'd0, 1'b0);
    pulse_cs();
    check_val("after_timeout_period", period, 32'h3000);
    check_val("after_timeout_no_err", err_pulses - err_base, 32'd1);

    // Commit coincident with cycle_start defers the copy.
    send_frame(8'h00, 32'h0000_4444, 1'b0);
    send_frame(8'h0F, 32'd0, 1'b1);
    check_val("coincide_pending", {31'd0, pending}, 32'd1);
    check_val("coincide_period_held", period, 32'h3000);
    pulse_cs();
    check_val("coincide_period_next", period, 32'h4444);
    check_val("coincide_pending_clr", {31'd0, pending}, 32'd0);

    // Shadow write coincident with copy: live takes the old shadow.
    send_frame(8'h00, 32'h0000_6000, 1'b0);
    send_frame(8'h0F, 32'd0, 1'b0);
    send_frame(8'h00, 32'h0000_7000, 1'b1);
    check_val("wr_copy_live_old", period, 32'h6000);
    check_val("wr_copy_pending_clr", {31'd0, pending}, 32'd0);
    send_frame(8'h0F, 32'd0, 1'b0);
    pulse_cs();
    check_val("wr_copy_shadow_new", period, 32'h7000);

    // Reset in the middle of the data bytes.
    send_frame(8'h0F, 32'd0, 1'b0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk_pll);
    check_defaults("midrst");
    check_val("midrst_ready", {31'd0, rx_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk_pll);
    send_frame(8'h01, 32'h0000_0099, 1'b0);
    send_frame(8'h0F, 32'd0, 1'b0);
    pulse_cs();
    check_val("post_rst_p1width", p1width, 32'h99);
    check_val("post_rst_period", period, 32'd20000);
    check_val("post_rst_pre_att", {25'd0, pre_att}, 32'd127);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
